// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, start-bit validation at half a bit,
// mid-bit sampling, one-cycle data_en / frame_err strobes and break recovery.
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge on rx_s
// START_BIT | counting half a bit, then re-checking the start bit
// DATA_BITS | sampling 8 data bits LSB-first at mid-bit
// STOP_BIT  | sampling the stop bit at mid-bit
// WAIT_IDLE | framing error seen, holding off until the line returns high
module uart_rx #(
    parameter int CLK_FREQ_KHz  = 50000,
    parameter int BAUD_RATE_BPS = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       data_en,
    output logic [7:0] data,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int BIT_CLOCKS  = (CLK_FREQ_KHz * 1000) / BAUD_RATE_BPS;
    localparam int HALF_CLOCKS = BIT_CLOCKS / 2;
    localparam int CNT_W       = $clog2(BIT_CLOCKS);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLOCKS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CLOCKS - 1);

    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        START_BIT = 5'b00010,
        DATA_BITS = 5'b00100,
        STOP_BIT  = 5'b01000,
        WAIT_IDLE = 5'b10000
    } state_t;

    state_t           state;
    logic             rx_s1;
    logic             rx_s;
    logic [CNT_W-1:0] bit_clk_cnt;
    logic [2:0]       data_bit_cnt;
    logic [7:0]       shift_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rx_s1        <= 1'b1;
            rx_s         <= 1'b1;
            bit_clk_cnt  <= '0;
            data_bit_cnt <= '0;
            shift_data   <= '0;
            data         <= '0;
            data_en      <= 1'b0;
            frame_err    <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            rx_s1     <= rx;
            rx_s      <= rx_s1;
            data_en   <= 1'b0;
            frame_err <= 1'b0;

            // rx_busy is registered alongside every transition so it tracks state exactly
            case (state)
                IDLE: begin
                    bit_clk_cnt  <= '0;
                    data_bit_cnt <= '0;
                    if (!rx_s) begin
                        state   <= START_BIT;
                        rx_busy <= 1'b1;
                    end
                end

                START_BIT: begin
                    if (bit_clk_cnt == HALF_LAST) begin
                        bit_clk_cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA_BITS;
                        end else begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        bit_clk_cnt <= bit_clk_cnt + 1'b1;
                    end
                end

                DATA_BITS: begin
                    if (bit_clk_cnt == BIT_LAST) begin
                        bit_clk_cnt <= '0;
                        shift_data  <= {rx_s, shift_data[7:1]};
                        if (data_bit_cnt == 3'd7) begin
                            data_bit_cnt <= '0;
                            state        <= STOP_BIT;
                        end else begin
                            data_bit_cnt <= data_bit_cnt + 1'b1;
                        end
                    end else begin
                        bit_clk_cnt <= bit_clk_cnt + 1'b1;
                    end
                end

                STOP_BIT: begin
                    if (bit_clk_cnt == BIT_LAST) begin
                        bit_clk_cnt <= '0;
                        if (rx_s) begin
                            data    <= shift_data;
                            data_en <= 1'b1;
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end else begin
                        bit_clk_cnt <= bit_clk_cnt + 1'b1;
                    end
                end

                WAIT_IDLE: begin
                    if (rx_s) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
